// File: rtl/wbu_pkg.sv
// -----------------------------------------------------------------------------
// wbu_pkg -- shared constants and types for the writeback unit
//
// Purpose : register-file address/data widths, queue depth, queue entry
//           layout, writeback source selection encoding and a small address
//           compare helper shared by wbu and wbu_fifo.
// Ports   : none (package).
// Config  : nothing here depends on WBU_FWD_EN; both builds share this file.
// -----------------------------------------------------------------------------
package wbu_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int WBU_FIFO_DEPTH = 2;
    localparam int WBU_CNT_WIDTH  = 2;

    // One queued mul/div completion. A cleared valid bit marks an entry that
    // was killed by a younger ex write to the same register; it still occupies
    // its slot until it reaches the head and is popped without a write.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] waddr;
        logic [REG_DATA_WIDTH-1:0] wdata;
    } wbu_entry_t;

    // Which source drives the registered regfile write port next cycle.
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_EX     = 2'd1,
        SEL_FIFO   = 2'd2,
        SEL_BYPASS = 2'd3
    } wbu_sel_e;

    // True when two register addresses match and do not name x0.
    function automatic logic addr_match(
        input logic [REG_ADDR_WIDTH-1:0] a,
        input logic [REG_ADDR_WIDTH-1:0] b
    );
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/wbu_fifo.sv
// -----------------------------------------------------------------------------
// wbu_fifo -- 2-entry completion queue of the writeback unit
//
// Purpose : holds accepted mul/div completions that could not be written back
//           immediately. Provides storage, 1-bit wrapping read/write pointers,
//           occupancy count, WAW kill of matching entries and the pending-write
//           hazard lookup (plus forwarding data when WBU_FWD_EN is defined).
//
// Ports   : clk, rst            clock, asynchronous active-low reset
//           flush_i             clear every entry, pointers and count
//           push_i/_waddr/_wdata  append a completion at the write pointer
//           pop_i               remove the head entry (caller ensures count>0)
//           kill_i/kill_waddr_i invalidate every valid entry with that waddr
//           raddr1_i, raddr2_i  hazard query addresses
//           count_o             occupancy 0..2
//           head_valid_o/_waddr_o/_wdata_o  head entry contents
//           hit1_o, hit2_o      a valid entry targets the query address
//           fwd1_data_o, fwd2_data_o  youngest matching wdata (WBU_FWD_EN only)
// -----------------------------------------------------------------------------
module wbu_fifo
    import wbu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [REG_ADDR_WIDTH-1:0] push_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] push_wdata_i,
    input  logic                      pop_i,
    input  logic                      kill_i,
    input  logic [REG_ADDR_WIDTH-1:0] kill_waddr_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2_i,
    output logic [WBU_CNT_WIDTH-1:0]  count_o,
    output logic                      head_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] head_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] head_wdata_o,
    output logic                      hit1_o,
    output logic                      hit2_o
`ifdef WBU_FWD_EN
    ,
    output logic [REG_DATA_WIDTH-1:0] fwd1_data_o,
    output logic [REG_DATA_WIDTH-1:0] fwd2_data_o
`endif
);

    wbu_entry_t               entry_q [WBU_FIFO_DEPTH];
    wbu_entry_t               entry_d [WBU_FIFO_DEPTH];
    logic                     rptr_q, rptr_d;
    logic                     wptr_q, wptr_d;
    logic [WBU_CNT_WIDTH-1:0] count_q, count_d;

    // With two slots the write pointer always addresses the older occupied
    // slot when full, and its partner holds the youngest entry. When only one
    // slot is occupied the slot at wptr has a cleared valid bit, so treating
    // it as "older" never produces a false match.
    logic old_idx, young_idx;
    logic m1_old, m1_young, m2_old, m2_young;

    // Next-state: flush wins over everything; otherwise kill, pop and push
    // are applied in that order. The caller never pushes into a full queue
    // nor pops an empty one, so the pop and push slots never coincide.
    always_comb begin
        entry_d = entry_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            for (int i = 0; i < WBU_FIFO_DEPTH; i++) begin
                entry_d[i] = '0;
            end
            rptr_d  = 1'b0;
            wptr_d  = 1'b0;
            count_d = '0;
        end else begin
            if (kill_i) begin
                for (int i = 0; i < WBU_FIFO_DEPTH; i++) begin
                    if (entry_q[i].valid && (entry_q[i].waddr == kill_waddr_i)) begin
                        entry_d[i].valid = 1'b0;
                    end
                end
            end
            if (pop_i) begin
                entry_d[rptr_q].valid = 1'b0;
                rptr_d                = ~rptr_q;
            end
            if (push_i) begin
                entry_d[wptr_q].valid = 1'b1;
                entry_d[wptr_q].waddr = push_waddr_i;
                entry_d[wptr_q].wdata = push_wdata_i;
                wptr_d                = ~wptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WBU_FIFO_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < WBU_FIFO_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Hazard lookup over valid (unkilled) entries; x0 never hits.
    always_comb begin
        old_idx   = wptr_q;
        young_idx = ~wptr_q;
        m1_old    = entry_q[old_idx].valid   && addr_match(entry_q[old_idx].waddr,   raddr1_i);
        m1_young  = entry_q[young_idx].valid && addr_match(entry_q[young_idx].waddr, raddr1_i);
        m2_old    = entry_q[old_idx].valid   && addr_match(entry_q[old_idx].waddr,   raddr2_i);
        m2_young  = entry_q[young_idx].valid && addr_match(entry_q[young_idx].waddr, raddr2_i);
    end

    assign hit1_o = m1_old | m1_young;
    assign hit2_o = m2_old | m2_young;

`ifdef WBU_FWD_EN
    // The youngest match carries the value the regfile will finally hold.
    assign fwd1_data_o = m1_young ? entry_q[young_idx].wdata :
                         m1_old   ? entry_q[old_idx].wdata   : '0;
    assign fwd2_data_o = m2_young ? entry_q[young_idx].wdata :
                         m2_old   ? entry_q[old_idx].wdata   : '0;
`endif

    assign count_o      = count_q;
    assign head_valid_o = entry_q[rptr_q].valid;
    assign head_waddr_o = entry_q[rptr_q].waddr;
    assign head_wdata_o = entry_q[rptr_q].wdata;

endmodule

// File: rtl/wbu.sv
// -----------------------------------------------------------------------------
// wbu -- writeback unit
//
// Purpose : merges single-cycle execute results and out-of-band mul/div
//           completions onto one registered regfile write port. The execute
//           port always wins; mul/div completions wait in a 2-entry queue
//           (wbu_fifo) or bypass it when the queue is empty and ex is idle.
//
// Ports   : clk, rst                      clock, asynchronous active-low reset
//           ex_we_i, ex_waddr_i, ex_wdata_i     execute-stage result
//           md_valid_i, md_waddr_i, md_wdata_i  mul/div completion
//           md_ready_o                    completion accepted when valid&&ready
//           flush_i                       discard all queued completions
//           reg_we_o, reg_waddr_o, reg_wdata_o  registered regfile write
//           pend_raddr1_i, pend_raddr2_i  hazard query addresses
//           pend_hit1_o, pend_hit2_o      queued write pending for that reg
//           wb_busy_o                     queue full
//           fwd1_data_o, fwd2_data_o      forwarding data (WBU_FWD_EN only)
//
// Config  : define WBU_FWD_EN to add the forwarding data outputs; without it
//           consumers stall on pend_hit*.
// -----------------------------------------------------------------------------
module wbu
    import wbu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] ex_wdata_i,
    input  logic                      md_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] md_waddr_i,
    input  logic [REG_DATA_WIDTH-1:0] md_wdata_i,
    output logic                      md_ready_o,
    input  logic                      flush_i,
    output logic                      reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata_o,
    input  logic [REG_ADDR_WIDTH-1:0] pend_raddr1_i,
    input  logic [REG_ADDR_WIDTH-1:0] pend_raddr2_i,
    output logic                      pend_hit1_o,
    output logic                      pend_hit2_o,
    output logic                      wb_busy_o
`ifdef WBU_FWD_EN
    ,
    output logic [REG_DATA_WIDTH-1:0] fwd1_data_o,
    output logic [REG_DATA_WIDTH-1:0] fwd2_data_o
`endif
);

    logic [WBU_CNT_WIDTH-1:0]  fifo_count;
    logic                      head_valid;
    logic [REG_ADDR_WIDTH-1:0] head_waddr;
    logic [REG_DATA_WIDTH-1:0] head_wdata;

    logic     ex_write;
    logic     md_accept;
    logic     fifo_push;
    logic     fifo_pop;
    wbu_sel_e sel;

    logic                      reg_we_q,    reg_we_d;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
    logic [REG_DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;

    // An ex write to x0 is no write at all, so it neither claims the port
    // nor kills queued entries.
    assign ex_write = ex_we_i && (ex_waddr_i != '0);

    // Ready depends on registered occupancy only; a full queue never lets a
    // completion through in the same cycle as a pop.
    assign md_ready_o = (fifo_count < 2'd2);
    assign wb_busy_o  = (fifo_count == 2'd2);
    assign md_accept  = md_valid_i && md_ready_o && !flush_i;

    // Source selection. A popped head whose valid bit was cleared by a WAW
    // kill is consumed without a write. Completions to x0 are accepted but
    // never queued or written. A completion racing an ex write to the same
    // register is already stale and is dropped instead of queued.
    always_comb begin
        sel       = SEL_NONE;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        if (ex_write) begin
            sel = SEL_EX;
        end else if (!flush_i && (fifo_count != '0)) begin
            fifo_pop = 1'b1;
            if (head_valid) begin
                sel = SEL_FIFO;
            end
        end else if (md_accept && (fifo_count == '0) && (md_waddr_i != '0)) begin
            sel = SEL_BYPASS;
        end
        if (md_accept && (md_waddr_i != '0) && (sel != SEL_BYPASS) &&
            !(ex_write && (md_waddr_i == ex_waddr_i))) begin
            fifo_push = 1'b1;
        end
    end

    // Output register inputs; idle cycles drive zeros on address and data.
    always_comb begin
        reg_we_d    = 1'b0;
        reg_waddr_d = '0;
        reg_wdata_d = '0;
        case (sel)
            SEL_EX: begin
                reg_we_d    = 1'b1;
                reg_waddr_d = ex_waddr_i;
                reg_wdata_d = ex_wdata_i;
            end
            SEL_FIFO: begin
                reg_we_d    = 1'b1;
                reg_waddr_d = head_waddr;
                reg_wdata_d = head_wdata;
            end
            SEL_BYPASS: begin
                reg_we_d    = 1'b1;
                reg_waddr_d = md_waddr_i;
                reg_wdata_d = md_wdata_i;
            end
            default: begin
                reg_we_d    = 1'b0;
            end
        endcase
    end

    // Registered regfile write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;

    wbu_fifo u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .push_i       (fifo_push),
        .push_waddr_i (md_waddr_i),
        .push_wdata_i (md_wdata_i),
        .pop_i        (fifo_pop),
        .kill_i       (ex_write),
        .kill_waddr_i (ex_waddr_i),
        .raddr1_i     (pend_raddr1_i),
        .raddr2_i     (pend_raddr2_i),
        .count_o      (fifo_count),
        .head_valid_o (head_valid),
        .head_waddr_o (head_waddr),
        .head_wdata_o (head_wdata),
        .hit1_o       (pend_hit1_o),
        .hit2_o       (pend_hit2_o)
`ifdef WBU_FWD_EN
        ,
        .fwd1_data_o  (fwd1_data_o),
        .fwd2_data_o  (fwd2_data_o)
`endif
    );

endmodule

// File: tb/tb_wbu.sv
// -----------------------------------------------------------------------------
// tb_wbu -- self-checking bench for the writeback unit
//
// Directed steps drive one cycle of inputs each. Every regfile write the
// bench expects is pushed onto a scoreboard queue at the step that should
// select it; a negedge monitor pops and compares each write the DUT emits
// and flags any write nobody expected. Forwarding checks are compiled in
// when WBU_FWD_EN is defined.
// -----------------------------------------------------------------------------
module tb_wbu;

    logic        clk;
    logic        rst;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        md_valid_i;
    logic [4:0]  md_waddr_i;
    logic [31:0] md_wdata_i;
    logic        md_ready_o;
    logic        flush_i;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic [4:0]  pend_raddr1_i;
    logic [4:0]  pend_raddr2_i;
    logic        pend_hit1_o;
    logic        pend_hit2_o;
    logic        wb_busy_o;
`ifdef WBU_FWD_EN
    logic [31:0] fwd1_data_o;
    logic [31:0] fwd2_data_o;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  errors;
    int  checks;

    wbu dut (
        .clk           (clk),
        .rst           (rst),
        .ex_we_i       (ex_we_i),
        .ex_waddr_i    (ex_waddr_i),
        .ex_wdata_i    (ex_wdata_i),
        .md_valid_i    (md_valid_i),
        .md_waddr_i    (md_waddr_i),
        .md_wdata_i    (md_wdata_i),
        .md_ready_o    (md_ready_o),
        .flush_i       (flush_i),
        .reg_we_o      (reg_we_o),
        .reg_waddr_o   (reg_waddr_o),
        .reg_wdata_o   (reg_wdata_o),
        .pend_raddr1_i (pend_raddr1_i),
        .pend_raddr2_i (pend_raddr2_i),
        .pend_hit1_o   (pend_hit1_o),
        .pend_hit2_o   (pend_hit2_o),
        .wb_busy_o     (wb_busy_o)
`ifdef WBU_FWD_EN
        ,
        .fwd1_data_o   (fwd1_data_o),
        .fwd2_data_o   (fwd2_data_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for the active edge, then drives one cycle's worth of inputs.
    task automatic applyStimulus(input int ewe, input int ea, input int ed,
                                 input int mv, input int ma, input int mdat,
                                 input int fl);
        @(posedge clk);
        #1;
        ex_we_i    = 1'(ewe);
        ex_waddr_i = 5'(ea);
        ex_wdata_i = 32'(ed);
        md_valid_i = 1'(mv);
        md_waddr_i = 5'(ma);
        md_wdata_i = 32'(mdat);
        flush_i    = 1'(fl);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expectWrite(input int a, input int d);
        wr_t w;
        w.a = 5'(a);
        w.d = 32'(d);
        sb.push_back(w);
    endtask

    // Scoreboard monitor: every emitted write must be the oldest expected one.
    always @(negedge clk) begin
        if (rst === 1'b1 && reg_we_o === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_write: observed addr=%0d data=%h expected no write",
                       reg_waddr_o, reg_wdata_o);
            end
            if (sb.size() != 0) begin
                wr_t w;
                w = sb.pop_front();
                checkOutput("wr_addr", 32'(reg_waddr_o), 32'(w.a));
                checkOutput("wr_data", reg_wdata_o, w.d);
            end
        end
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b0;
        ex_we_i       = 1'b0;
        ex_waddr_i    = 5'd0;
        ex_wdata_i    = 32'd0;
        md_valid_i    = 1'b0;
        md_waddr_i    = 5'd0;
        md_wdata_i    = 32'd0;
        flush_i       = 1'b0;
        pend_raddr1_i = 5'd0;
        pend_raddr2_i = 5'd0;

        // Reset state
        #2;
        checkOutput("rst_reg_we",    32'(reg_we_o),    32'd0);
        checkOutput("rst_reg_waddr", 32'(reg_waddr_o), 32'd0);
        checkOutput("rst_reg_wdata", reg_wdata_o,      32'd0);
        checkOutput("rst_md_ready",  32'(md_ready_o),  32'd1);
        checkOutput("rst_busy",      32'(wb_busy_o),   32'd0);
        checkOutput("rst_hit1",      32'(pend_hit1_o), 32'd0);
        checkOutput("rst_hit2",      32'(pend_hit2_o), 32'd0);
        #15;
        rst = 1'b1;

        // Ex write appears one cycle later for exactly one cycle
        applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0);
        expectWrite(5, 32'h1234);
        idle();
        #1;
        checkOutput("ex_we_next", 32'(reg_we_o), 32'd1);
        idle();
        #1;
        checkOutput("ex_we_once", 32'(reg_we_o), 32'd0);

        // Bypass into an empty queue
        applyStimulus(0, 0, 0, 1, 7, 32'hAA, 0);
        expectWrite(7, 32'hAA);
        #1;
        checkOutput("byp_ready", 32'(md_ready_o), 32'd1);
        idle();
        pend_raddr1_i = 5'd7;
        #1;
        checkOutput("byp_we",        32'(reg_we_o),    32'd1);
        checkOutput("byp_not_queue", 32'(pend_hit1_o), 32'd0);
        checkOutput("byp_busy",      32'(wb_busy_o),   32'd0);

        // Backpressure: ex busy x1..x4 while three completions arrive
        applyStimulus(1, 1, 32'h101, 1, 10, 32'hA0, 0);
        expectWrite(1, 32'h101);
        #1;
        checkOutput("bp_ready_c0", 32'(md_ready_o), 32'd1);
        applyStimulus(1, 2, 32'h102, 1, 11, 32'hB0, 0);
        expectWrite(2, 32'h102);
        #1;
        checkOutput("bp_ready_c1", 32'(md_ready_o), 32'd1);
        applyStimulus(1, 3, 32'h103, 1, 12, 32'hC0, 0);
        expectWrite(3, 32'h103);
        pend_raddr1_i = 5'd10;
        pend_raddr2_i = 5'd11;
        #1;
        checkOutput("bp_ready_full", 32'(md_ready_o),  32'd0);
        checkOutput("bp_busy_full",  32'(wb_busy_o),   32'd1);
        checkOutput("bp_hit10",      32'(pend_hit1_o), 32'd1);
        checkOutput("bp_hit11",      32'(pend_hit2_o), 32'd1);
        applyStimulus(1, 4, 32'h104, 1, 12, 32'hC0, 0);
        expectWrite(4, 32'h104);
        applyStimulus(0, 0, 0, 1, 12, 32'hC0, 0);
        expectWrite(10, 32'hA0);
        #1;
        checkOutput("bp_no_popthru", 32'(md_ready_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 12, 32'hC0, 0);
        expectWrite(11, 32'hB0);
        #1;
        checkOutput("bp_ready_again", 32'(md_ready_o), 32'd1);
        idle();
        expectWrite(12, 32'hC0);
        idle();
        idle();
        pend_raddr1_i = 5'd12;
        #1;
        checkOutput("bp_drained_hit", 32'(pend_hit1_o), 32'd0);

        // WAW kill of a queued entry
        applyStimulus(1, 20, 32'h5, 1, 9, 32'h11, 0);
        expectWrite(20, 32'h5);
        applyStimulus(1, 9, 32'h22, 0, 0, 0, 0);
        expectWrite(9, 32'h22);
        pend_raddr1_i = 5'd9;
        #1;
        checkOutput("waw_hit_before", 32'(pend_hit1_o), 32'd1);
        idle();
        #1;
        checkOutput("waw_hit_killed", 32'(pend_hit1_o), 32'd0);
        idle();
        idle();

        // Same-cycle md completion to the ex target is dropped
        applyStimulus(1, 9, 32'h33, 1, 9, 32'h44, 0);
        expectWrite(9, 32'h33);
        idle();
        #1;
        checkOutput("same_cycle_drop", 32'(pend_hit1_o), 32'd0);
        idle();

        // Flush of a full queue; ex write in the flush cycle still lands
        applyStimulus(1, 1, 32'h201, 1, 13, 32'hD1, 0);
        expectWrite(1, 32'h201);
        applyStimulus(1, 2, 32'h202, 1, 14, 32'hD2, 0);
        expectWrite(2, 32'h202);
        applyStimulus(1, 3, 32'h333, 1, 15, 32'hD3, 1);
        expectWrite(3, 32'h333);
        pend_raddr1_i = 5'd13;
        pend_raddr2_i = 5'd14;
        #1;
        checkOutput("flush_busy_before", 32'(wb_busy_o),   32'd1);
        checkOutput("flush_hit_before",  32'(pend_hit1_o), 32'd1);
        idle();
        #1;
        checkOutput("flush_busy_after",  32'(wb_busy_o),   32'd0);
        checkOutput("flush_ready_after", 32'(md_ready_o),  32'd1);
        checkOutput("flush_hit1_after",  32'(pend_hit1_o), 32'd0);
        checkOutput("flush_hit2_after",  32'(pend_hit2_o), 32'd0);
        idle();
        idle();

        // Flush with one queued entry ignores an offered completion
        applyStimulus(1, 4, 32'h204, 1, 16, 32'hE6, 0);
        expectWrite(4, 32'h204);
        applyStimulus(0, 0, 0, 1, 18, 32'hE8, 1);
        #1;
        checkOutput("flush_ready_state", 32'(md_ready_o), 32'd1);
        idle();
        pend_raddr1_i = 5'd16;
        pend_raddr2_i = 5'd18;
        #1;
        checkOutput("flush1_hit16", 32'(pend_hit1_o), 32'd0);
        checkOutput("flush1_hit18", 32'(pend_hit2_o), 32'd0);
        idle();
        idle();

        // Reset asserted mid-drain
        applyStimulus(1, 1, 32'h301, 1, 13, 32'hD1, 0);
        expectWrite(1, 32'h301);
        applyStimulus(1, 2, 32'h302, 1, 14, 32'hD2, 0);
        expectWrite(2, 32'h302);
        idle();
        expectWrite(13, 32'hD1);
        idle();
        pend_raddr1_i = 5'd14;
        #6;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_we",    32'(reg_we_o),    32'd0);
        checkOutput("mid_rst_waddr", 32'(reg_waddr_o), 32'd0);
        checkOutput("mid_rst_wdata", reg_wdata_o,      32'd0);
        checkOutput("mid_rst_ready", 32'(md_ready_o),  32'd1);
        checkOutput("mid_rst_busy",  32'(wb_busy_o),   32'd0);
        checkOutput("mid_rst_hit",   32'(pend_hit1_o), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle();
        idle();
        idle();
        #1;
        checkOutput("post_rst_hit", 32'(pend_hit1_o), 32'd0);
        applyStimulus(0, 0, 0, 1, 16, 32'h66, 0);
        expectWrite(16, 32'h66);
        idle();

        // x0 completions are accepted and never written
        applyStimulus(0, 0, 0, 1, 0, 32'hDEAD, 0);
        #1;
        checkOutput("x0_ready", 32'(md_ready_o), 32'd1);
        idle();
        #1;
        checkOutput("x0_no_write", 32'(reg_we_o), 32'd0);

        // Ex write to x0 leaves the port free for a bypass
        applyStimulus(1, 0, 32'hBEEF, 1, 17, 32'h77, 0);
        expectWrite(17, 32'h77);
        idle();
        #1;
        checkOutput("ex_x0_bypass", 32'(reg_waddr_o), 32'd17);
        idle();

        // Two queued writes to x3: hazard lookup and youngest-value forwarding
        applyStimulus(1, 2, 32'h402, 1, 3, 32'h55, 0);
        expectWrite(2, 32'h402);
        applyStimulus(1, 4, 32'h404, 1, 3, 32'h66, 0);
        expectWrite(4, 32'h404);
        pend_raddr1_i = 5'd3;
        pend_raddr2_i = 5'd5;
        #1;
        checkOutput("fwd_hit1_one", 32'(pend_hit1_o), 32'd1);
`ifdef WBU_FWD_EN
        checkOutput("fwd1_data_one", fwd1_data_o, 32'h55);
`endif
        idle();
        expectWrite(3, 32'h55);
        #1;
        checkOutput("fwd_hit1_two", 32'(pend_hit1_o), 32'd1);
        checkOutput("fwd_hit2_none", 32'(pend_hit2_o), 32'd0);
`ifdef WBU_FWD_EN
        checkOutput("fwd1_youngest", fwd1_data_o, 32'h66);
        checkOutput("fwd2_zero",     fwd2_data_o, 32'h0);
`endif
        idle();
        expectWrite(3, 32'h66);
        idle();
        idle();
        idle();
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
